ex_ctrl_skid_stage: RTL

Parametrised ID/EX execute-control pipeline register with a ready/valid handshake and a 2-entry skid buffer. It carries the execute-stage control bundle (operand-A select, operand-B select, ALU op, func3, func7) from decode to execute. Compared with a plain stall/flush register, it adds:
- back-pressure without a combinational ready path from execute to decode;
- explicit valid tracking;
- NOP bubble encoding driven whenever the stage is empty.

---
 rtl/ex_ctrl_pkg.sv | 31 +++
 rtl/ex_ctrl_sat_cnt.sv | 17 +
 rtl/ex_ctrl_skid_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the ID/EX execute-control skid stage.
package ex_ctrl_pkg;

   localparam int EX_ALU_OP_W    = 7;
   localparam int EX_ALU_FUNC3_W = 3;
   localparam int EX_ALU_FUNC7_W = 7;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } ex_ctrl_state_e;

   typedef struct packed {
      logic                      reg_to_pc;
      logic                      alu_src;
      logic [EX_ALU_OP_W-1:0]    alu_op;
      logic [EX_ALU_FUNC3_W-1:0] alu_func3;
      logic [EX_ALU_FUNC7_W-1:0] alu_func7;
   } ex_ctrl_t;

   // addi x0,x0,0 with immediate operand B
   localparam ex_ctrl_t EX_CTRL_NOP = '{
      reg_to_pc: 1'b0,
      alu_src:   1'b1,
      alu_op:    7'b0010011,
      alu_func3: 3'b000,
      alu_func7: 7'b0000000
   };

endpackage

// File: rtl/ex_ctrl_sat_cnt.sv
// 16-bit saturating event counter, cleared only by asynchronous reset.
module ex_ctrl_sat_cnt (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   output logic [15:0] cnt
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (inc && (cnt != 16'hFFFF)) begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/ex_ctrl_skid_stage.sv
// ID/EX execute-control register with ready/valid handshake and 2-entry skid buffer.
// Optional performance counters are built only when EX_CTRL_PERF_EN is defined.
//
// state | meaning
// EMPTY | no bundle held, outputs show the NOP bubble
// ONE   | main entry valid, skid free
// FULL  | main and skid valid, input not accepted
module ex_ctrl_skid_stage
   import ex_ctrl_pkg::*;
#(
   parameter int                         ALU_OP_WIDTH    = EX_ALU_OP_W,
   parameter int                         ALU_FUNC3_WIDTH = EX_ALU_FUNC3_W,
   parameter int                         ALU_FUNC7_WIDTH = EX_ALU_FUNC7_W,
   parameter logic [ALU_OP_WIDTH-1:0]    NOP_ALU_OP      = EX_CTRL_NOP.alu_op,
   parameter logic                       NOP_ALU_SRC     = EX_CTRL_NOP.alu_src
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       reg_to_pc_in,
   input  logic                       alu_src_in,
   input  logic [ALU_OP_WIDTH-1:0]    alu_op_in,
   input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_in,
   input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       reg_to_pc_out,
   output logic                       alu_src_out,
   output logic [ALU_OP_WIDTH-1:0]    alu_op_out,
   output logic [ALU_FUNC3_WIDTH-1:0] alu_func3_out,
   output logic [ALU_FUNC7_WIDTH-1:0] alu_func7_out,
   output logic [15:0]                perf_stall_cnt,
   output logic [15:0]                perf_flush_cnt
);

   localparam int BW = 2 + ALU_OP_WIDTH + ALU_FUNC3_WIDTH + ALU_FUNC7_WIDTH;
   localparam logic [BW-1:0] NOP_B = {1'b0, NOP_ALU_SRC, NOP_ALU_OP,
                                      {ALU_FUNC3_WIDTH{1'b0}}, {ALU_FUNC7_WIDTH{1'b0}}};

   ex_ctrl_state_e  st_q, st_d;
   logic [BW-1:0]   main_q, skid_q, in_b;
   logic            in_fire, out_fire;
   logic            load_main_in, load_main_skid, load_skid;

   assign in_b      = {reg_to_pc_in, alu_src_in, alu_op_in, alu_func3_in, alu_func7_in};
   // Ready depends only on held state and flush/reset, never on out_ready.
   assign in_ready  = (st_q != FULL) && !flush && !reset;
   assign out_valid = (st_q != EMPTY);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_comb begin
      st_d           = st_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         st_d = EMPTY;
      end else begin
         unique case (st_q)
            EMPTY: begin
               if (in_fire) begin
                  st_d         = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire) begin
                  st_d      = FULL;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  st_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  st_d           = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: st_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q   <= EMPTY;
         main_q <= NOP_B;
         skid_q <= NOP_B;
      end else begin
         st_q <= st_d;
         if (load_main_in) begin
            main_q <= in_b;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_b;
         end
      end
   end

   assign {reg_to_pc_out, alu_src_out, alu_op_out, alu_func3_out, alu_func7_out} =
      out_valid ? main_q : NOP_B;

`ifdef EX_CTRL_PERF_EN
   ex_ctrl_sat_cnt u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid && !out_ready),
      .cnt   (perf_stall_cnt)
   );

   ex_ctrl_sat_cnt u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush),
      .cnt   (perf_flush_cnt)
   );
`else
   assign perf_stall_cnt = 16'd0;
   assign perf_flush_cnt = 16'd0;
`endif

endmodule
